// File: rtl/mult_div_if.sv
// Handshake and data bundle between the execute stage and the multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Fixed 34-edge sequence: issue, 32 radix-2 steps, sign fix-up and write-back.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [1:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, addend, quo, rem;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    neg_a  = bus.op[0] & bus.src_a[WIDTH-1];
    neg_b  = bus.op[0] & bus.src_b[WIDTH-1];
    mag_a  = neg_a ? -bus.src_a : bus.src_a;
    mag_b  = neg_b ? -bus.src_b : bus.src_b;

    addend = acc_q[0] ? opnd_q : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    prod   = neg_res_q ? -acc_q : acc_q;
    quo    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Multiply keeps the multiplicand in opnd and shifts the multiplier
          // out of acc's low half; divide keeps the divisor and shifts the
          // dividend out of acc's low half while quotient bits shift in.
          opnd_d    = bus.op[1] ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
          raw_a_d   = bus.src_a;
          op_d      = bus.op;
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          dz_d      = (bus.src_b == '0);
          cnt_d     = '0;
          state_d   = CALC;
        end else begin
          if (bus.mthi) hi_d = bus.src_a;
          if (bus.mtlo) lo_d = bus.src_a;
        end
      end
      CALC: begin
        if (!op_q[1]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: results, latency, MTHI/MTLO, ignored starts, reset abort.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a single edge; returns 1 time unit after that edge (E0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    step();
    bus.start = 1'b0;
  endtask

  // Advance until done is seen or 40 edges elapse; edges counts edges after E0.
  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_cmp++;
    if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    n_cmp++;
    if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
  endtask

  task automatic test_multu_timing();
    int bcnt, dcnt, dpos;
    bcnt = 0; dcnt = 0; dpos = -1;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) begin
        dcnt++;
        dpos = i;
        n_cmp++;
        if (bus.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h exp fffffffe", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h exp 00000001", bus.lo); end
      end
      step();
    end
    n_cmp++;
    if (bcnt != 33) begin n_err++; $display("FAIL multu_busy_cycles got %0d exp 33", bcnt); end
    n_cmp++;
    if (dcnt != 1) begin n_err++; $display("FAIL multu_done_cycles got %0d exp 1", dcnt); end
    n_cmp++;
    if (dpos != 33) begin n_err++; $display("FAIL multu_done_edge got %0d exp 33", dpos); end
  endtask

  task automatic test_back_to_back();
    int e;
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(e);
    n_cmp++;
    if (e != 33) begin n_err++; $display("FAIL mult_latency got %0d exp 33", e); end
    n_cmp++;
    if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h exp ffffffff", bus.hi); end
    n_cmp++;
    if (bus.lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h exp ffffffeb", bus.lo); end
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got %b exp 1", bus.busy); end
    wait_done(e);
    n_cmp++;
    if (e != 33) begin n_err++; $display("FAIL div_latency got %0d exp 33", e); end
    n_cmp++;
    if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h exp fffffffd", bus.lo); end
    n_cmp++;
    if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h exp ffffffff", bus.hi); end
    step();
  endtask

  task automatic test_div_corners();
    int e;
    issue(2'b10, 32'd100, 32'd0);
    wait_done(e);
    n_cmp++;
    if (bus.lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo got %h exp ffffffff", bus.lo); end
    n_cmp++;
    if (bus.hi !== 32'h0000_0064) begin n_err++; $display("FAIL divz_hi got %h exp 00000064", bus.hi); end
    step();
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e);
    n_cmp++;
    if (bus.lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo got %h exp 80000000", bus.lo); end
    n_cmp++;
    if (bus.hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h exp 0", bus.hi); end
    step();
    issue(2'b11, 32'd7, 32'hFFFF_FFFE);
    wait_done(e);
    n_cmp++;
    if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL divneg_lo got %h exp fffffffd", bus.lo); end
    n_cmp++;
    if (bus.hi !== 32'h0000_0001) begin n_err++; $display("FAIL divneg_hi got %h exp 00000001", bus.hi); end
    step();
  endtask

  task automatic test_mthi_mtlo();
    int e;
    bus.src_a = 32'h1234_5678;
    bus.mthi  = 1'b1;
    step();
    bus.mthi  = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_idle got %h exp 12345678", bus.hi); end
    bus.src_a = 32'hCAFE_F00D;
    bus.mtlo  = 1'b1;
    step();
    bus.mtlo  = 1'b0;
    n_cmp++;
    if (bus.lo !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mtlo_idle got %h exp cafef00d", bus.lo); end
    // start together with mthi: start takes priority, HI untouched
    bus.mthi = 1'b1;
    issue(2'b00, 32'd2, 32'd3);
    bus.mthi = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL start_wins_hi got %h exp 12345678", bus.hi); end
    step();
    bus.src_a = 32'hDEAD_BEEF;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    step();
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_busy got %h exp 12345678", bus.hi); end
    n_cmp++;
    if (bus.lo !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mtlo_busy got %h exp cafef00d", bus.lo); end
    wait_done(e);
    n_cmp++;
    if (bus.hi !== 32'h0) begin n_err++; $display("FAIL mt_op_hi got %h exp 0", bus.hi); end
    n_cmp++;
    if (bus.lo !== 32'd6) begin n_err++; $display("FAIL mt_op_lo got %h exp 6", bus.lo); end
    step();
  endtask

  task automatic test_start_while_busy();
    int e, extra;
    issue(2'b10, 32'd1000, 32'd7);
    for (int i = 0; i < 4; i++) step();
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.src_a = 32'd5;
    bus.src_b = 32'd5;
    step();
    bus.start = 1'b0;
    wait_done(e);
    e = e + 5;
    n_cmp++;
    if (e != 33) begin n_err++; $display("FAIL busy_start_latency got %0d exp 33", e); end
    n_cmp++;
    if (bus.lo !== 32'd142) begin n_err++; $display("FAIL busy_start_lo got %0d exp 142", bus.lo); end
    n_cmp++;
    if (bus.hi !== 32'd6) begin n_err++; $display("FAIL busy_start_hi got %0d exp 6", bus.hi); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_err++; $display("FAIL busy_start_extra got %0d exp 0", extra); end
  endtask

  task automatic test_reset_abort();
    int dseen;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    n_cmp++;
    if (bus.hi !== 32'h0) begin n_err++; $display("FAIL abort_hi got %h exp 0", bus.hi); end
    n_cmp++;
    if (bus.lo !== 32'h0) begin n_err++; $display("FAIL abort_lo got %h exp 0", bus.lo); end
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dseen++;
      step();
    end
    n_cmp++;
    if (dseen != 0) begin n_err++; $display("FAIL abort_done got %0d exp 0", dseen); end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    test_reset();
    test_multu_timing();
    test_back_to_back();
    test_div_corners();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
